// File: rtl/hbbus_pkg.sv
// Shared hexbus definitions: default word width, 2-bit word-tag encodings,
// and the fill-counter width helper used by the buffering blocks.
package hbbus_pkg;

  localparam int HB_W = 34;

  typedef enum logic [1:0] {
    HB_TAG_ACK  = 2'b00,
    HB_TAG_ADDR = 2'b01,
    HB_TAG_DATA = 2'b10,
    HB_TAG_INT  = 2'b11
  } hb_tag_e;

  // A buffer of 2^lgflen words needs lgflen+1 bits to count 0..2^lgflen.
  function automatic int hb_fill_w(input int lgflen);
    return lgflen + 1;
  endfunction

endpackage

// File: rtl/hbfifo_mem.sv
// Circular memory of 2^LGFLEN-1 entries; pointers wrap by compare-and-clear
// since the depth is not a power of two.
module hbfifo_mem
  import hbbus_pkg::*;
#(
  parameter int W      = HB_W,
  parameter int LGFLEN = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_empty
);

  localparam int DEPTH = (1 << LGFLEN) - 1;
  localparam logic [LGFLEN-1:0] LAST = LGFLEN'(DEPTH - 1);

  logic [W-1:0]      r_mem [DEPTH];
  logic [LGFLEN-1:0] r_wr_ptr;
  logic [LGFLEN-1:0] r_rd_ptr;
  logic [LGFLEN-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr)
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + LGFLEN'(1);
      if (i_rd)
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + LGFLEN'(1);
      case ({i_wr, i_rd})
        2'b10:   r_count <= r_count + LGFLEN'(1);
        2'b01:   r_count <= r_count - LGFLEN'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (i_wr)
      r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/hbfifo.sv
// Hexbus elastic buffer: registered output stage in front of hbfifo_mem.
// Define HBFIFO_PROTOCOL_EN to add the sticky upstream hold-rule checker (o_err).
module hbfifo
  import hbbus_pkg::*;
#(
  parameter int W      = HB_W,
  parameter int LGFLEN = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stb,
  input  logic [W-1:0]    i_word,
  output logic            o_busy,
  output logic            o_stb,
  output logic [W-1:0]    o_word,
  input  logic            i_busy,
  output logic [LGFLEN:0] o_fill,
  output logic            o_err
);

  localparam int FW = hb_fill_w(LGFLEN);
  localparam logic [FW-1:0] CAP = FW'(1 << LGFLEN);

  // Handshake: a word moves upstream when i_stb && !o_busy, and downstream
  // when o_stb && !i_busy; a producer seeing busy must hold stb and word.
  logic            r_stb;
  logic [W-1:0]    r_word;
  logic            r_busy;
  logic [FW-1:0]   r_fill;
  logic [FW-1:0]   w_fill_nxt;
  logic            w_wr;
  logic            w_rd;
  logic            w_out_free;
  logic            w_load_mem;
  logic            w_bypass;
  logic            w_mem_wr;
  logic            w_mem_empty;
  logic [W-1:0]    w_mem_rdata;

  assign w_wr       = i_stb && !r_busy;
  assign w_rd       = r_stb && !i_busy;
  assign w_out_free = !r_stb || w_rd;
  assign w_load_mem = w_out_free && !w_mem_empty;
  assign w_bypass   = w_out_free && w_mem_empty && w_wr;
  assign w_mem_wr   = w_wr && !w_bypass;

  hbfifo_mem #(
    .W      (W),
    .LGFLEN (LGFLEN)
  ) u_mem (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (w_mem_wr),
    .i_wdata (i_word),
    .i_rd    (w_load_mem),
    .o_rdata (w_mem_rdata),
    .o_empty (w_mem_empty)
  );

  always_comb begin
    w_fill_nxt = r_fill;
    case ({w_wr, w_rd})
      2'b10:   w_fill_nxt = r_fill + FW'(1);
      2'b01:   w_fill_nxt = r_fill - FW'(1);
      default: w_fill_nxt = r_fill;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stb  <= 1'b0;
      r_word <= '0;
      r_busy <= 1'b0;
      r_fill <= '0;
    end else begin
      r_fill <= w_fill_nxt;
      r_busy <= (w_fill_nxt == CAP);
      // Memory head has priority so older words always leave first.
      if (w_load_mem) begin
        r_stb  <= 1'b1;
        r_word <= w_mem_rdata;
      end else if (w_bypass) begin
        r_stb  <= 1'b1;
        r_word <= i_word;
      end else if (w_rd) begin
        r_stb  <= 1'b0;
      end
    end
  end

  assign o_stb  = r_stb;
  assign o_word = r_word;
  assign o_busy = r_busy;
  assign o_fill = r_fill;

`ifdef HBFIFO_PROTOCOL_EN
  logic         r_last_stb;
  logic [W-1:0] r_last_word;
  logic         r_last_busy;
  logic         r_err;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_stb  <= 1'b0;
      r_last_word <= '0;
      r_last_busy <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_last_stb  <= i_stb;
      r_last_word <= i_word;
      r_last_busy <= r_busy;
      if (r_last_stb && r_last_busy && ({i_stb, i_word} != {r_last_stb, r_last_word}))
        r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: doc/hbfifo.md
# hbfifo

Elastic buffer for the hexbus word stream, between a word producer (packer/command decoder) and a slower consumer (hex generator/serializer). It accepts W-bit words with a strobe/busy handshake and stores up to 2^LGFLEN of them. Its output strobe and word are registered and held stable while the consumer is busy, so the downstream interface meets the hexbus hold rule by construction.

## Interface
- W, 34: word width in bits (2-bit tag plus 32-bit payload).
- LGFLEN, 2: log2 of total capacity; capacity = 2^LGFLEN words, output register included; LGFLEN ≥ 1.
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_stb  in  1  upstream word valid.
- i_word  in  W  upstream word.
- o_busy  out  1  buffer full; upstream must hold i_stb/i_word.
- o_stb  out  1  downstream word valid.
- o_word  out  W  downstream word.
- i_busy  in  1  downstream cannot accept.
- o_fill  out  LGFLEN+1  words held, output register included.
- o_err  out  1  sticky input-protocol violation; present only under HBFIFO_PROTOCOL_EN.

## Operation
- Write: i_stb && !o_busy. Read: o_stb && !i_busy.
- Storage: o_stb/o_word output register plus a circular memory of 2^LGFLEN−1 entries. The memory has LGFLEN-bit read and write pointers wrapping modulo 2^LGFLEN−1 via explicit compare-and-clear, not power-of-two masking.
- o_fill updates each cycle:
  - write only: +1.
  - read only: −1.
  - both or neither: unchanged.
- o_busy = (o_fill == 2^LGFLEN). It is a registered output, computed from the next fill value.
- Output register load priority, evaluated each cycle:
  - Output empty, or output being read, and memory non-empty: load the memory head and advance the read pointer.
  - Output empty, or output being read, memory empty, write occurring: load i_word directly (bypass).
  - Otherwise: hold.
- Any write not taken by the bypass goes to the memory tail.
- While o_stb && i_busy, o_stb and o_word do not change.
- Order is strict FIFO. Words are never dropped or duplicated.

## Timing
- Reset values: o_stb=0, o_word=0, o_busy=0, o_fill=0, o_err=0, pointers=0. Reset mid-operation discards all stored words on the next edge.
- Latency: a word written at edge N into an empty buffer appears on o_stb/o_word after edge N (visible in cycle N+1).
- Throughput: one word per cycle, sustained, when i_busy=0.
- Full: o_busy rises the cycle after the write that fills the buffer. A read in that same cycle keeps it low.
- Simultaneous read and write at full cannot occur, because the write is blocked by o_busy. At fill 1 with both, the bypass path keeps output continuous.
- Empty read is impossible, because o_stb=0.

## Configuration
- HBFIFO_PROTOCOL_EN defined:
  - Registers last i_stb, i_word and o_busy.
  - Sets o_err (sticky until reset) when last_stb && last_busy && {i_stb,i_word} differs from {last_stb,last_word}.
- Undefined: o_err tied to 0 and checker logic absent.

## Structure
- Shared package hbbus_pkg: the W default, the tag encodings of the 2-bit word header, and the fill-width helper constant.
- Natural sub-module: hbfifo_mem, a dual-pointer memory with the wrap logic. The output register and handshake stay in hbfifo.

## Test plan
- Reset, then a single write of 34'h1_1234_5678 with i_busy=0 -> o_stb=1 the next cycle with that word, o_fill=1; o_stb=0 and o_fill=0 one cycle later.
- i_busy=1, write 5 words 1..5 on consecutive cycles (LGFLEN=2):
  - Words 1..4 accepted; o_busy=1 after the 4th; word 5 held.
  - o_word stays 1 throughout; o_fill=4.
- From full, release i_busy -> outputs 1,2,3,4,5 on consecutive cycles. o_busy drops one cycle after the first read.
- Continuous write and read for 20 words with i_busy=0 -> output order identical, no gaps after the first, o_fill stays 1, pointers wrap without loss.
- Assert i_reset while at fill 3 -> next cycle o_stb=0, o_fill=0, o_busy=0. A subsequent write of 34'h2_0000_00AA emerges unchanged.
- HBFIFO_PROTOCOL_EN, buffer full, upstream changes i_word while o_busy=1 -> o_err=1 the next cycle, staying 1 until reset. Without the macro, o_err stays 0.
